// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-requester round-robin arbiter and sequencer in front of a
//            shared data memory. One transaction is outstanding at a time.
//            The accepted request is turned into a single-cycle memory
//            strobe. Read data returns after a fixed latency. Each
//            transaction ends with a one-cycle response pulse to the
//            requester that owns it.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH          address / data width
//   LAT            memory read latency, mem_ren cycle to rdata-valid cycle
//                  (legal range 1..7)
// Ports
//   clk            clock, all state changes on the rising edge
//   rst            synchronous active-low reset
//   reqN_valid_i   requester N has a request (N = 0 fetch, 1 load/store)
//   reqN_ready_o   requester N is accepted this cycle (combinational)
//   reqN_wen_i     1 = write, 0 = read
//   reqN_addr_i    byte address, passed through unchanged
//   reqN_wdata_i   write data
//   respN_valid_o  one-cycle completion pulse to the owning requester
//   resp_rdata_o   read data shared by both requesters
//   mem_ren_o      memory read strobe (one cycle)
//   mem_wen_o      memory write strobe (one cycle)
//   mem_addr_o     memory address, qualified by the strobes
//   mem_wdata_o    memory write data, qualified by mem_wen_o
//   mem_rdata_i    memory read data, valid LAT cycles after mem_ren_o
// ============================================================================
module mem_arbiter #(
    parameter int WIDTH = 32,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic             req0_wen_i,
    input  logic [WIDTH-1:0] req0_addr_i,
    input  logic [WIDTH-1:0] req0_wdata_i,

    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic             req1_wen_i,
    input  logic [WIDTH-1:0] req1_addr_i,
    input  logic [WIDTH-1:0] req1_wdata_i,

    output logic             resp0_valid_o,
    output logic             resp1_valid_o,
    output logic [WIDTH-1:0] resp_rdata_o,

    output logic             mem_ren_o,
    output logic             mem_wen_o,
    output logic [WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0] mem_wdata_o,
    input  logic [WIDTH-1:0] mem_rdata_i
);

    // The WAIT counter starts at LAT-1. It reaches zero in the cycle
    // in which the memory presents its read data.
    localparam logic [2:0] c_lat_m1 = 3'(LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           state_q;
    logic             ptr_q;        // last-grant pointer
    logic             owner_q;      // requester owning the in-flight transaction
    logic             wen_q;        // in-flight transaction is a write
    logic [2:0]       cnt_q;        // read latency countdown
    logic             rdy_en_q;     // set one cycle after reset is released
    logic             resp0_q;
    logic             resp1_q;
    logic [WIDTH-1:0] rdata_q;
    logic             ren_q;
    logic             wstrb_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;

    logic             w_idle;
    logic             w_grant;
    logic             w_hs;
    logic             w_sel_wen;
    logic [WIDTH-1:0] w_sel_addr;
    logic [WIDTH-1:0] w_sel_wdata;

    // ------------------------------------------------------------------
    // Arbitration and ready generation.
    // ready is also gated by rst. A cycle that is being reset can then
    // never look like a handshake to a requester.
    // ------------------------------------------------------------------
    always_comb begin
        w_idle = rst && rdy_en_q && (state_q == S_IDLE);

        // If both requesters are valid, the one not granted last time wins.
        if (req0_valid_i && req1_valid_i) begin
            w_grant = ~ptr_q;
        end else begin
            w_grant = req1_valid_i;
        end

        req0_ready_o = w_idle && req0_valid_i && !w_grant;
        req1_ready_o = w_idle && req1_valid_i &&  w_grant;
        w_hs         = req0_ready_o || req1_ready_o;

        w_sel_wen    = w_grant ? req1_wen_i   : req0_wen_i;
        w_sel_addr   = w_grant ? req1_addr_i  : req0_addr_i;
        w_sel_wdata  = w_grant ? req1_wdata_i : req0_wdata_i;
    end

    // ------------------------------------------------------------------
    // Sequencer. The strobes and the response pulse default low each
    // cycle, so each is a single-cycle pulse. The memory address and data
    // registers are loaded at handshake time. The strobe is therefore
    // already registered in the ISSUE cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= 1'b1;
            owner_q  <= 1'b0;
            wen_q    <= 1'b0;
            cnt_q    <= 3'd0;
            rdy_en_q <= 1'b0;
            resp0_q  <= 1'b0;
            resp1_q  <= 1'b0;
            rdata_q  <= '0;
            ren_q    <= 1'b0;
            wstrb_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            resp0_q  <= 1'b0;
            resp1_q  <= 1'b0;
            ren_q    <= 1'b0;
            wstrb_q  <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (w_hs) begin
                        owner_q <= w_grant;
                        ptr_q   <= w_grant;
                        wen_q   <= w_sel_wen;
                        addr_q  <= w_sel_addr;
                        wdata_q <= w_sel_wdata;
                        ren_q   <= !w_sel_wen;
                        wstrb_q <= w_sel_wen;
                        state_q <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (wen_q) begin
                        // A write completes as soon as its strobe is issued.
                        resp0_q <= !owner_q;
                        resp1_q <=  owner_q;
                        state_q <= S_RESP;
                    end else begin
                        cnt_q   <= c_lat_m1;
                        state_q <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        rdata_q <= mem_rdata_i;
                        resp0_q <= !owner_q;
                        resp1_q <=  owner_q;
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end

                S_RESP: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign resp0_valid_o = resp0_q;
    assign resp1_valid_o = resp1_q;
    assign resp_rdata_o  = rdata_q;
    assign mem_ren_o     = ren_q;
    assign mem_wen_o     = wstrb_q;
    assign mem_addr_o    = addr_q;
    assign mem_wdata_o   = wdata_q;

endmodule
`default_nettype wire
